// File: rtl/phase1_pair_scheduler.sv
// Phase 1 pair scheduler: sweeps every reference cell of a periodic 3-D grid and
// issues its 14 half-shell neighbour pairs to the force pipeline over valid/ready.
module phase1_pair_scheduler #(
    parameter int CELLS_X = 4,
    parameter int CELLS_Y = 4,
    parameter int CELLS_Z = 4,
    parameter int CELL_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              phase1_ready,
    input  logic              pipe_idle,
    input  logic              pair_ready,
    output logic              pair_valid,
    output logic [CELL_W-1:0] ref_cell,
    output logic [CELL_W-1:0] nbr_cell,
    output logic [3:0]        nbr_k,
    output logic              pair_last,
    output logic              phase1_done
);

    localparam int XW = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;
    localparam int YW = (CELLS_Y > 1) ? $clog2(CELLS_Y) : 1;
    localparam int ZW = (CELLS_Z > 1) ? $clog2(CELLS_Z) : 1;

    localparam logic [XW-1:0] X_MAX = XW'(CELLS_X - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(CELLS_Y - 1);
    localparam logic [ZW-1:0] Z_MAX = ZW'(CELLS_Z - 1);
    localparam logic [3:0]    K_MAX = 4'd13;

    localparam logic [CELL_W-1:0] CX_W = CELL_W'(CELLS_X);
    localparam logic [CELL_W-1:0] CY_W = CELL_W'(CELLS_Y);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        D_ZERO,
        D_MINUS,
        D_PLUS
    } delta_t;

    state_t        state, state_next;
    logic [XW-1:0] x_q, x_next;
    logic [YW-1:0] y_q, y_next;
    logic [ZW-1:0] z_q, z_next;
    logic [3:0]    k_q, k_next;
    logic          done_q, done_next;

    logic          at_max;
    delta_t        dx, dy, dz;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic [ZW-1:0] nz;

    assign at_max = (x_q == X_MAX) && (y_q == Y_MAX) && (z_q == Z_MAX) && (k_q == K_MAX);

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dx = D_ZERO;
        dy = D_ZERO;
        dz = D_ZERO;
        case (k_q)
            4'd1:  begin dz = D_PLUS; dy = D_MINUS; dx = D_MINUS; end
            4'd2:  begin dz = D_PLUS; dy = D_MINUS;               end
            4'd3:  begin dz = D_PLUS; dy = D_MINUS; dx = D_PLUS;  end
            4'd4:  begin dz = D_PLUS;               dx = D_MINUS; end
            4'd5:  begin dz = D_PLUS;                             end
            4'd6:  begin dz = D_PLUS;               dx = D_PLUS;  end
            4'd7:  begin dz = D_PLUS; dy = D_PLUS;  dx = D_MINUS; end
            4'd8:  begin dz = D_PLUS; dy = D_PLUS;                end
            4'd9:  begin dz = D_PLUS; dy = D_PLUS;  dx = D_PLUS;  end
            4'd10: begin              dy = D_PLUS;  dx = D_MINUS; end
            4'd11: begin              dy = D_PLUS;                end
            4'd12: begin              dy = D_PLUS;  dx = D_PLUS;  end
            4'd13: begin                            dx = D_PLUS;  end
            default: ;
        endcase
    end

    // Periodic wrap: a step only ever crosses one edge, so compare-and-step replaces a modulo.
    always_comb begin
        nx = x_q;
        if (dx == D_MINUS)     nx = (x_q == '0)    ? X_MAX : x_q - XW'(1);
        else if (dx == D_PLUS) nx = (x_q == X_MAX) ? '0    : x_q + XW'(1);

        ny = y_q;
        if (dy == D_MINUS)     ny = (y_q == '0)    ? Y_MAX : y_q - YW'(1);
        else if (dy == D_PLUS) ny = (y_q == Y_MAX) ? '0    : y_q + YW'(1);

        nz = z_q;
        if (dz == D_MINUS)     nz = (z_q == '0)    ? Z_MAX : z_q - ZW'(1);
        else if (dz == D_PLUS) nz = (z_q == Z_MAX) ? '0    : z_q + ZW'(1);
    end

    always_comb begin
        state_next = state;
        x_next     = x_q;
        y_next     = y_q;
        z_next     = z_q;
        k_next     = k_q;
        done_next  = 1'b0;

        unique case (state)
            IDLE: begin
                if (phase1_ready) state_next = ISSUE;
            end

            ISSUE: begin
                if (!phase1_ready) begin
                    state_next = IDLE;
                    x_next     = '0;
                    y_next     = '0;
                    z_next     = '0;
                    k_next     = '0;
                end else if (pair_ready) begin
                    if (k_q == K_MAX) begin
                        k_next = '0;
                        if (x_q == X_MAX) begin
                            x_next = '0;
                            if (y_q == Y_MAX) begin
                                y_next = '0;
                                z_next = (z_q == Z_MAX) ? '0 : z_q + ZW'(1);
                            end else begin
                                y_next = y_q + YW'(1);
                            end
                        end else begin
                            x_next = x_q + XW'(1);
                        end
                    end else begin
                        k_next = k_q + 4'd1;
                    end
                    if (at_max) state_next = DRAIN;
                end
            end

            DRAIN: begin
                if (!phase1_ready) begin
                    state_next = IDLE;
                    x_next     = '0;
                    y_next     = '0;
                    z_next     = '0;
                    k_next     = '0;
                end else if (pipe_idle) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end

            DONE: begin
                if (!phase1_ready) begin
                    state_next = IDLE;
                    x_next     = '0;
                    y_next     = '0;
                    z_next     = '0;
                    k_next     = '0;
                end else begin
                    done_next = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            k_q    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            x_q    <= x_next;
            y_q    <= y_next;
            z_q    <= z_next;
            k_q    <= k_next;
            done_q <= done_next;
        end
    end

    assign pair_valid  = (state == ISSUE);
    assign pair_last   = pair_valid && at_max;
    assign phase1_done = done_q;
    assign nbr_k       = k_q;
    assign ref_cell    = CELL_W'(x_q) + CX_W * (CELL_W'(y_q) + CY_W * CELL_W'(z_q));
    assign nbr_cell    = CELL_W'(nx)  + CX_W * (CELL_W'(ny)  + CY_W * CELL_W'(nz));

endmodule

// File: tb/tb_phase1_pair_scheduler.sv
// Scoreboard bench for phase1_pair_scheduler: a reference model preloads every expected
// pair of a sweep, a negedge monitor pops one per handshake; directed steps cover the edges.
module tb_phase1_pair_scheduler;

    localparam int NX = 4;
    localparam int NY = 4;
    localparam int NZ = 4;
    localparam int CW = 6;
    localparam int TOTAL = 14 * NX * NY * NZ;

    typedef struct {
        int ref_c;
        int nbr_c;
        int k;
        int last;
    } pair_t;

    logic          clk;
    logic          reset;
    logic          phase1_ready;
    logic          pipe_idle;
    logic          pair_ready;
    logic          pair_valid;
    logic [CW-1:0] ref_cell;
    logic [CW-1:0] nbr_cell;
    logic [3:0]    nbr_k;
    logic          pair_last;
    logic          phase1_done;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    hs_count = 0;
    pair_t sb_q[$];

    int dx_t[14] = '{0, -1, 0, 1, -1, 0, 1, -1, 0, 1, -1, 0, 1, 1};
    int dy_t[14] = '{0, -1, -1, -1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    int dz_t[14] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};

    phase1_pair_scheduler #(
        .CELLS_X(NX), .CELLS_Y(NY), .CELLS_Z(NZ), .CELL_W(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .phase1_ready(phase1_ready),
        .pipe_idle   (pipe_idle),
        .pair_ready  (pair_ready),
        .pair_valid  (pair_valid),
        .ref_cell    (ref_cell),
        .nbr_cell    (nbr_cell),
        .nbr_k       (nbr_k),
        .pair_last   (pair_last),
        .phase1_done (phase1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic pair_t model(input int idx);
        pair_t p;
        int c, x, y, z, k;
        k = idx % 14;
        c = idx / 14;
        x = c % NX;
        y = (c / NX) % NY;
        z = c / (NX * NY);
        p.ref_c = c;
        p.nbr_c = ((x + dx_t[k] + NX) % NX)
                + NX * (((y + dy_t[k] + NY) % NY) + NY * ((z + dz_t[k] + NZ) % NZ));
        p.k     = k;
        p.last  = (idx == TOTAL - 1) ? 1 : 0;
        return p;
    endfunction

    task automatic load_sweep();
        sb_q.delete();
        hs_count = 0;
        for (int i = 0; i < TOTAL; i++) sb_q.push_back(model(i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int n, input int budget);
        for (int i = 0; i < budget && hs_count < n; i++) tick();
        check("hs_reached", hs_count, n);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !phase1_done; i++) tick();
        check("done_reached", phase1_done, 1);
    endtask

    // Monitor: inputs and outputs are stable at the negedge; a valid&&ready seen here
    // is the handshake taken on the following rising edge.
    logic  stall_prev = 1'b0;
    pair_t stall_snap;
    always @(negedge clk) begin
        if (reset && pair_valid) begin
            if (stall_prev) begin
                check("stall_ref", ref_cell, stall_snap.ref_c);
                check("stall_nbr", nbr_cell, stall_snap.nbr_c);
                check("stall_k", nbr_k, stall_snap.k);
            end
            if (pair_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got handshake %0d, expected none (t=%0t)", hs_count, $time);
                end else begin
                    pair_t e;
                    e = sb_q.pop_front();
                    check("sb_ref", ref_cell, e.ref_c);
                    check("sb_nbr", nbr_cell, e.nbr_c);
                    check("sb_k", nbr_k, e.k);
                    check("sb_last", pair_last, e.last);
                end
                hs_count++;
                stall_prev = 1'b0;
            end else begin
                stall_prev       = 1'b1;
                stall_snap.ref_c = ref_cell;
                stall_snap.nbr_c = nbr_cell;
                stall_snap.k     = nbr_k;
                stall_snap.last  = pair_last;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with phase1_ready high
        reset        = 1'b0;
        phase1_ready = 1'b1;
        pipe_idle    = 1'b1;
        pair_ready   = 1'b1;
        repeat (3) tick();
        check("rst_valid", pair_valid, 0);
        check("rst_done", phase1_done, 0);
        check("rst_ref", ref_cell, 0);
        check("rst_last", pair_last, 0);

        load_sweep();
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("start_valid", pair_valid, 1);
        check("p0_ref", ref_cell, 0);
        check("p0_nbr", nbr_cell, 0);
        check("p0_k", nbr_k, 0);
        tick();
        check("p1_nbr", nbr_cell, 31);
        check("p1_k", nbr_k, 1);
        tick();
        check("p2_nbr", nbr_cell, 28);
        check("p2_k", nbr_k, 2);

        // Full sweep with pair_ready tied high, then a slow drain
        for (int i = 0; i < 2000 && !pair_last; i++) tick();
        check("last_flag", pair_last, 1);
        check("last_ref", ref_cell, 63);
        check("last_nbr", nbr_cell, 60);
        check("last_k", nbr_k, 13);
        check("last_hs", hs_count, TOTAL - 1);
        pipe_idle = 1'b0;
        tick();
        check("drain_valid", pair_valid, 0);
        check("drain_done", phase1_done, 0);
        repeat (4) begin
            tick();
            check("drain_hold_done", phase1_done, 0);
        end
        pipe_idle = 1'b1;
        tick();
        check("done_one_edge", phase1_done, 1);
        check("sweep1_total", hs_count, TOTAL);
        check("sweep1_sb_empty", sb_q.size(), 0);
        phase1_ready = 1'b0;
        tick();
        check("done_clear", phase1_done, 0);
        check("idle_valid", pair_valid, 0);
        tick();
        check("idle_stays", pair_valid, 0);

        // Backpressure at pair #5
        load_sweep();
        phase1_ready = 1'b1;
        wait_hs(5, 50);
        pair_ready = 1'b0;
        repeat (4) begin
            tick();
            check("bp_valid", pair_valid, 1);
        end
        check("bp_ref", ref_cell, 0);
        check("bp_nbr", nbr_cell, 16);
        check("bp_k", nbr_k, 5);
        pair_ready = 1'b1;
        wait_done(2000);
        check("sweep2_total", hs_count, TOTAL);
        check("sweep2_sb_empty", sb_q.size(), 0);
        phase1_ready = 1'b0;
        tick();

        // Abort at pair #100
        load_sweep();
        phase1_ready = 1'b1;
        wait_hs(100, 200);
        check("p100_ref", ref_cell, 7);
        check("p100_nbr", nbr_cell, 19);
        check("p100_k", nbr_k, 2);
        phase1_ready = 1'b0;
        pair_ready   = 1'b0;
        tick();
        check("abort_valid", pair_valid, 0);
        check("abort_ref", ref_cell, 0);
        check("abort_k", nbr_k, 0);
        load_sweep();
        phase1_ready = 1'b1;
        pair_ready   = 1'b1;
        tick();
        check("restart_valid", pair_valid, 1);
        check("restart_ref", ref_cell, 0);
        check("restart_k", nbr_k, 0);

        // Asynchronous reset pulse between edges
        wait_hs(20, 100);
        check("p20_ref", ref_cell, 1);
        check("p20_nbr", nbr_cell, 18);
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", pair_valid, 0);
        check("async_ref", ref_cell, 0);
        check("async_nbr", nbr_cell, 0);
        check("async_k", nbr_k, 0);
        #3;
        reset = 1'b1;
        load_sweep();
        tick();
        check("post_rst_valid", pair_valid, 1);
        check("post_rst_ref", ref_cell, 0);
        wait_done(2000);
        check("sweep4_total", hs_count, TOTAL);
        check("sweep4_sb_empty", sb_q.size(), 0);
        phase1_ready = 1'b0;
        tick();
        check("final_done_clear", phase1_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
